bingo_board_map: RTL and testbench

- Owns the 5x5 bingo board state. It generates a shuffled board of the numbers 1..25, clears cells as numbers are called, and counts completed lines.
- Drives the packed `map` bus read by the per-pixel window renderer. A cell value of 0 means "marked" and renders as background.
- Sits directly upstream of the display path. It is fed by game control: shuffle request, seed, and called number.

---
 rtl/bingo_board_map_pkg.sv | 23 ++
 rtl/bingo_line_counter.sv | 37 +++
 rtl/bingo_board_map.sv | 130 +++++++++++++
 tb/tb_bingo_board_map.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bingo_board_map_pkg.sv
// Shared constants, FSM encoding and cell-index helper for the bingo board and its renderer.
package bingo_board_map_pkg;

    localparam int BOARD_DIM = 5;
    localparam int CELLS     = 25;
    localparam int CELL_W    = 5;
    localparam int MAP_W     = 125;
    localparam int MAX_LINES = 12;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHUFFLE,
        ST_DONE
    } state_t;

    function automatic int cell_idx(input int x, input int y);
        return x + BOARD_DIM * y;
    endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// Counts completed rows, columns and diagonals (all five cells zero) of a packed 5x5 board.
module bingo_line_counter
    import bingo_board_map_pkg::*;
(
    input  logic [MAP_W-1:0] map_i,
    output logic [3:0]       lines_o
);

    logic [CELLS-1:0]     clr;
    logic [MAX_LINES-1:0] done;

    always_comb begin
        for (int c = 0; c < CELLS; c++) begin
            clr[c] = (map_i[CELL_W*c +: CELL_W] == '0);
        end
    end

    // Lines 0..4 are rows, 5..9 columns, 10 the main diagonal, 11 the anti-diagonal.
    always_comb begin
        done = '1;
        for (int y = 0; y < BOARD_DIM; y++) begin
            for (int x = 0; x < BOARD_DIM; x++) begin
                done[y]           = done[y] & clr[cell_idx(x, y)];
                done[BOARD_DIM+x] = done[BOARD_DIM+x] & clr[cell_idx(x, y)];
            end
        end
        for (int k = 0; k < BOARD_DIM; k++) begin
            done[10] = done[10] & clr[cell_idx(k, k)];
            done[11] = done[11] & clr[cell_idx(BOARD_DIM-1-k, k)];
        end
        lines_o = '0;
        for (int l = 0; l < MAX_LINES; l++) begin
            lines_o = lines_o + 4'(done[l]);
        end
    end

endmodule

// File: rtl/bingo_board_map.sv
// 5x5 bingo board: LFSR-driven Fisher-Yates shuffle, called-number marking and line/bingo tracking.
//   state      | meaning
//   ST_IDLE    | board stable; accepts shuffle or mark requests
//   ST_FILL    | rewrite board with 1..25, clearing all marks
//   ST_SHUFFLE | one LFSR step per cycle; swap cell i with r when r <= i
//   ST_DONE    | one-cycle completion pulse, then back to idle
module bingo_board_map
    import bingo_board_map_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          BINGO_LINES  = 5
) (
    input  logic              clk_25MHz,
    input  logic              all_rst,
    input  logic              shuffle_start,
    input  logic [15:0]       seed,
    input  logic              mark_valid,
    input  logic [4:0]        mark_num,
    output logic [MAP_W-1:0]  map,
    output logic              busy,
    output logic              shuffle_done,
    output logic              mark_hit,
    output logic [3:0]        lines,
    output logic              bingo
);

    localparam logic [3:0] BINGO_TH = 4'(BINGO_LINES);

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d, lfsr_step;
    logic [CELL_W-1:0]   cell_q [CELLS];
    logic [CELL_W-1:0]   cell_d [CELLS];
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          r;
    logic                hit_q, hit_d;
    logic [3:0]          lines_q, line_cnt;
    logic                bingo_q;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign r         = lfsr_step[4:0];

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cell_d  = cell_q;
        idx_d   = idx_q;
        hit_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (shuffle_start) begin
                    lfsr_d  = (seed == 16'h0000) ? DEFAULT_SEED : seed;
                    state_d = ST_FILL;
                end else if (mark_valid && mark_num != '0) begin
                    for (int c = 0; c < CELLS; c++) begin
                        if (cell_q[c] == mark_num) begin
                            cell_d[c] = '0;
                            hit_d     = 1'b1;
                        end
                    end
                end
            end
            ST_FILL: begin
                for (int c = 0; c < CELLS; c++) begin
                    cell_d[c] = CELL_W'(c + 1);
                end
                idx_d   = 5'(CELLS - 1);
                state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                lfsr_d = lfsr_step;
                // Out-of-range draws are rejected rather than reduced, keeping the shuffle unbiased.
                if (r <= idx_q) begin
                    cell_d[idx_q] = cell_q[r];
                    cell_d[r]     = cell_q[idx_q];
                    idx_d         = idx_q - 5'd1;
                    if (idx_q == 5'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (all_rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= DEFAULT_SEED;
            for (int c = 0; c < CELLS; c++) begin
                cell_q[c] <= CELL_W'(c + 1);
            end
            idx_q   <= '0;
            hit_q   <= 1'b0;
            lines_q <= '0;
            bingo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cell_q  <= cell_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            lines_q <= line_cnt;
            bingo_q <= (line_cnt >= BINGO_TH);
        end
    end

    always_comb begin
        map = '0;
        for (int c = 0; c < CELLS; c++) begin
            map[CELL_W*c +: CELL_W] = cell_q[c];
        end
    end

    bingo_line_counter u_line_counter (
        .map_i   (map),
        .lines_o (line_cnt)
    );

    assign busy         = (state_q == ST_FILL) || (state_q == ST_SHUFFLE);
    assign shuffle_done = (state_q == ST_DONE);
    assign mark_hit     = hit_q;
    assign lines        = lines_q;
    assign bingo        = bingo_q;

endmodule

// File: tb/tb_bingo_board_map.sv
// Directed bench for bingo_board_map: marking table with hand-computed line counts, plus shuffle sequences.
`timescale 1ns/1ps
module tb_bingo_board_map;

    logic         clk_25MHz = 1'b0;
    logic         all_rst = 1'b1;
    logic         shuffle_start = 1'b0;
    logic [15:0]  seed = 16'h0000;
    logic         mark_valid = 1'b0;
    logic [4:0]   mark_num = 5'd0;
    logic [124:0] map;
    logic         busy, shuffle_done, mark_hit, bingo;
    logic [3:0]   lines;

    always #20 clk_25MHz = ~clk_25MHz;

    bingo_board_map dut (
        .clk_25MHz    (clk_25MHz),
        .all_rst      (all_rst),
        .shuffle_start(shuffle_start),
        .seed         (seed),
        .mark_valid   (mark_valid),
        .mark_num     (mark_num),
        .map          (map),
        .busy         (busy),
        .shuffle_done (shuffle_done),
        .mark_hit     (mark_hit),
        .lines        (lines),
        .bingo        (bingo)
    );

    typedef struct {
        logic [4:0] num;
        logic       hit;
        logic [3:0] lines;
        logic       bingo;
    } mark_vec_t;

    mark_vec_t    vecs [31];
    int           n_vec = 0;
    int           n_err = 0;
    logic [4:0]   exp_cell [25];
    logic [4:0]   model_cell [25];
    logic [124:0] identity_map;
    logic [124:0] saved_1234;
    logic [124:0] saved_seed0;

    task automatic chk(input string nm, input logic [124:0] act, input logic [124:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    function automatic logic [124:0] pack_exp();
        logic [124:0] m;
        for (int c = 0; c < 25; c++) m[5*c +: 5] = exp_cell[c];
        return m;
    endfunction

    function automatic logic [124:0] pack_model();
        logic [124:0] m;
        for (int c = 0; c < 25; c++) m[5*c +: 5] = model_cell[c];
        return m;
    endfunction

    // Reference Fisher-Yates with rejection, driven by the x^16+x^14+x^13+x^11+1 Galois LFSR.
    task automatic model_shuffle(input logic [15:0] s, output int steps);
        logic [15:0] l;
        logic [4:0]  t;
        int          i, r;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int c = 0; c < 25; c++) model_cell[c] = 5'(c + 1);
        i = 24;
        steps = 0;
        while (i >= 1 && steps < 5000) begin
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            r = int'(l[4:0]);
            if (r <= i) begin
                t = model_cell[i];
                model_cell[i] = model_cell[r];
                model_cell[r] = t;
                i--;
            end
            steps++;
        end
    endtask

    task automatic run_shuffle(input logic [15:0] s, input bit disturb, input bit with_mark, input string tag);
        int          steps, n, hits;
        logic [31:0] seen;
        model_shuffle(s, steps);
        shuffle_start = 1'b1;
        seed          = s;
        mark_valid    = with_mark;
        mark_num      = 5'd9;
        tick();
        shuffle_start = 1'b0;
        seed          = 16'h0000;
        mark_valid    = 1'b0;
        mark_num      = 5'd0;
        chk({tag, "_busy_start"}, busy, 1'b1);
        chk({tag, "_no_hit_start"}, mark_hit, 1'b0);
        n = 0;
        hits = 0;
        while (!shuffle_done && n < 2000) begin
            if (disturb && n == 5) begin
                shuffle_start = 1'b1;
                seed          = 16'h5555;
                mark_valid    = 1'b1;
                mark_num      = 5'd3;
            end
            tick();
            shuffle_start = 1'b0;
            seed          = 16'h0000;
            mark_valid    = 1'b0;
            mark_num      = 5'd0;
            if (mark_hit) hits++;
            n++;
        end
        chk({tag, "_done_seen"}, shuffle_done, 1'b1);
        chk({tag, "_cycles"}, 125'(n), 125'(steps + 1));
        chk({tag, "_busy_done"}, busy, 1'b0);
        chk({tag, "_map"}, map, pack_model());
        chk({tag, "_lines"}, lines, 4'd0);
        chk({tag, "_bingo"}, bingo, 1'b0);
        chk({tag, "_hits_while_busy"}, 125'(hits), 125'd0);
        seen = '0;
        for (int c = 0; c < 25; c++) seen[map[5*c +: 5]] = 1'b1;
        chk({tag, "_perm"}, seen, 32'h03FF_FFFE);
        tick();
        chk({tag, "_done_pulse"}, shuffle_done, 1'b0);
    endtask

    initial begin
        int cell13;

        vecs[0]  = '{5'd7,  1'b1, 4'd0,  1'b0};
        vecs[1]  = '{5'd7,  1'b0, 4'd0,  1'b0};
        vecs[2]  = '{5'd0,  1'b0, 4'd0,  1'b0};
        vecs[3]  = '{5'd26, 1'b0, 4'd0,  1'b0};
        vecs[4]  = '{5'd31, 1'b0, 4'd0,  1'b0};
        vecs[5]  = '{5'd1,  1'b1, 4'd0,  1'b0};
        vecs[6]  = '{5'd2,  1'b1, 4'd0,  1'b0};
        vecs[7]  = '{5'd3,  1'b1, 4'd0,  1'b0};
        vecs[8]  = '{5'd4,  1'b1, 4'd0,  1'b0};
        vecs[9]  = '{5'd5,  1'b1, 4'd1,  1'b0};
        vecs[10] = '{5'd6,  1'b1, 4'd1,  1'b0};
        vecs[11] = '{5'd11, 1'b1, 4'd1,  1'b0};
        vecs[12] = '{5'd16, 1'b1, 4'd1,  1'b0};
        vecs[13] = '{5'd21, 1'b1, 4'd2,  1'b0};
        vecs[14] = '{5'd8,  1'b1, 4'd2,  1'b0};
        vecs[15] = '{5'd9,  1'b1, 4'd2,  1'b0};
        vecs[16] = '{5'd10, 1'b1, 4'd3,  1'b0};
        vecs[17] = '{5'd12, 1'b1, 4'd3,  1'b0};
        vecs[18] = '{5'd13, 1'b1, 4'd3,  1'b0};
        vecs[19] = '{5'd14, 1'b1, 4'd3,  1'b0};
        vecs[20] = '{5'd15, 1'b1, 4'd4,  1'b0};
        vecs[21] = '{5'd17, 1'b1, 4'd5,  1'b1};
        vecs[22] = '{5'd18, 1'b1, 4'd5,  1'b1};
        vecs[23] = '{5'd19, 1'b1, 4'd5,  1'b1};
        vecs[24] = '{5'd20, 1'b1, 4'd6,  1'b1};
        vecs[25] = '{5'd22, 1'b1, 4'd7,  1'b1};
        vecs[26] = '{5'd23, 1'b1, 4'd8,  1'b1};
        vecs[27] = '{5'd24, 1'b1, 4'd9,  1'b1};
        vecs[28] = '{5'd25, 1'b1, 4'd12, 1'b1};
        vecs[29] = '{5'd25, 1'b0, 4'd12, 1'b1};
        vecs[30] = '{5'd0,  1'b0, 4'd12, 1'b1};

        for (int c = 0; c < 25; c++) exp_cell[c] = 5'(c + 1);
        identity_map = pack_exp();

        // Reset
        all_rst = 1'b1;
        repeat (3) tick();
        all_rst = 1'b0;
        chk("rst_map", map, identity_map);
        chk("rst_cell0", map[4:0], 5'd1);
        chk("rst_cell24", map[124:120], 5'd25);
        chk("rst_lines", lines, 4'd0);
        chk("rst_bingo", bingo, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", shuffle_done, 1'b0);
        chk("rst_hit", mark_hit, 1'b0);

        // Marking table on the identity board
        for (int i = 0; i < 31; i++) begin
            mark_valid = 1'b1;
            mark_num   = vecs[i].num;
            tick();
            mark_valid = 1'b0;
            mark_num   = 5'd0;
            if (vecs[i].hit) exp_cell[int'(vecs[i].num) - 1] = 5'd0;
            chk($sformatf("mark%0d_num%0d_hit", i, vecs[i].num), mark_hit, vecs[i].hit);
            chk($sformatf("mark%0d_num%0d_map", i, vecs[i].num), map, pack_exp());
            tick();
            chk($sformatf("mark%0d_num%0d_pulse", i, vecs[i].num), mark_hit, 1'b0);
            chk($sformatf("mark%0d_num%0d_lines", i, vecs[i].num), lines, vecs[i].lines);
            chk($sformatf("mark%0d_num%0d_bingo", i, vecs[i].num), bingo, vecs[i].bingo);
        end

        // Shuffle, determinism and seed-zero substitution
        run_shuffle(16'h1234, 1'b0, 1'b0, "sh1234a");
        saved_1234 = map;

        model_shuffle(16'h1234, cell13);
        cell13 = 0;
        for (int c = 0; c < 25; c++) if (model_cell[c] == 5'd13) cell13 = c;
        model_cell[cell13] = 5'd0;
        mark_valid = 1'b1;
        mark_num   = 5'd13;
        tick();
        mark_valid = 1'b0;
        mark_num   = 5'd0;
        chk("post_shuffle_hit", mark_hit, 1'b1);
        chk("post_shuffle_map", map, pack_model());
        tick();
        chk("post_shuffle_lines", lines, 4'd0);

        run_shuffle(16'h1234, 1'b0, 1'b0, "sh1234b");
        chk("sh1234_repeat", map, saved_1234);

        run_shuffle(16'h0000, 1'b0, 1'b0, "sh0");
        saved_seed0 = map;
        run_shuffle(16'hACE1, 1'b0, 1'b0, "shace1");
        chk("seed0_vs_ace1", map, saved_seed0);

        // Requests during busy are dropped
        run_shuffle(16'h1234, 1'b1, 1'b0, "sh_disturb");
        chk("disturb_vs_clean", map, saved_1234);

        // Simultaneous shuffle and mark in idle: shuffle wins
        run_shuffle(16'h00FF, 1'b0, 1'b1, "sh_both");

        // Reset in the middle of a shuffle
        shuffle_start = 1'b1;
        seed          = 16'h4321;
        tick();
        shuffle_start = 1'b0;
        seed          = 16'h0000;
        repeat (6) tick();
        chk("midrst_busy_before", busy, 1'b1);
        all_rst = 1'b1;
        tick();
        all_rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_map", map, identity_map);
        chk("midrst_done", shuffle_done, 1'b0);
        chk("midrst_lines", lines, 4'd0);
        tick();
        chk("midrst_stays_idle", busy, 1'b0);
        chk("midrst_map_hold", map, identity_map);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
